// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int unsigned off_w);
    return a & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned off_w,
                                             input int unsigned idx_w);
    return (a >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned off_w,
                                           input int unsigned idx_w);
    return a >> (off_w + idx_w);
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a, input int unsigned off_w);
    return a & ~((32'd1 << off_w) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: asynchronous read port, one synchronous write port.
module icache_line_store #(
  parameter int LINES      = 8,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 27
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(LINES)-1:0]      rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_data,
  input  logic [$clog2(LINES)-1:0]      wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
  input  logic [TAG_W-1:0]              wr_tag,
  input  logic                          wr_word_en,
  input  logic [31:0]                   wr_data,
  input  logic                          set_valid,
  input  logic                          clr_valid
);

  logic [LINES-1:0] valid_d, valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][LINE_WORDS];

  always_comb begin
    valid_d = valid_q;
    if (clr_valid) valid_d[wr_idx] = 1'b0;
    if (set_valid) valid_d[wr_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (wr_word_en) data_q[wr_idx][wr_off] <= wr_data;
    if (set_valid)  tag_q[wr_idx]          <= wr_tag;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache_refill_responder.sv
// Direct-mapped word-addressed instruction cache with a line-refill FSM
// against a burst-returning instruction memory.
module icache_refill_responder
  import icache_pkg::*;
#(
  parameter int LINES      = 8,
  parameter int LINE_WORDS = 4,
  parameter int MISS_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  output logic [31:0]       data,
  output logic              hit,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [MISS_W-1:0] miss_count
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  state_e            state_d, state_q;
  logic [OFF_W-1:0]  beat_d, beat_q;
  logic [31:0]       mem_addr_d, mem_addr_q;
  logic [MISS_W-1:0] miss_d, miss_q;

  logic [OFF_W-1:0]  rd_off;
  logic [IDX_W-1:0]  rd_idx, fill_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, fill_tag, line_tag;
  logic              line_valid;
  logic [31:0]       line_word;
  logic              wr_word_en, set_valid, clr_valid;

  assign rd_off   = OFF_W'(addr_offset(addr, OFF_W));
  assign rd_idx   = IDX_W'(addr_index(addr, OFF_W, IDX_W));
  assign rd_tag   = TAG_W'(addr_tag(addr, OFF_W, IDX_W));
  assign fill_idx = IDX_W'(addr_index(mem_addr_q, OFF_W, IDX_W));
  assign fill_tag = TAG_W'(addr_tag(mem_addr_q, OFF_W, IDX_W));

  icache_line_store #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (rd_idx),
    .rd_off     (rd_off),
    .rd_valid   (line_valid),
    .rd_tag     (line_tag),
    .rd_data    (line_word),
    .wr_idx     (wr_idx),
    .wr_off     (beat_q),
    .wr_tag     (fill_tag),
    .wr_word_en (wr_word_en),
    .wr_data    (mem_rdata),
    .set_valid  (set_valid),
    .clr_valid  (clr_valid)
  );

  // Hits are suppressed during a refill so the fetch stage never races the line being written.
  assign hit        = (state_q == IDLE) && line_valid && (line_tag == rd_tag);
  assign data       = hit ? line_word : NOP_INSTR;
  assign mem_req    = (state_q == FILL);
  assign mem_addr   = mem_addr_q;
  assign miss_count = miss_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d    = state_q;
    beat_d     = beat_q;
    mem_addr_d = mem_addr_q;
    miss_d     = miss_q;
    wr_idx     = fill_idx;
    wr_word_en = 1'b0;
    set_valid  = 1'b0;
    clr_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d    = FILL;
          mem_addr_d = line_base(addr, OFF_W);
          beat_d     = '0;
          wr_idx     = rd_idx;
          clr_valid  = 1'b1;
          if (miss_q != '1) miss_d = miss_q + MISS_W'(1);
        end
      end
      FILL: begin
        if (mem_rvalid) begin
          wr_word_en = 1'b1;
          beat_d     = beat_q + OFF_W'(1);
          if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
            set_valid = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      mem_addr_q <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      mem_addr_q <= mem_addr_d;
      miss_q     <= miss_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_responder.sv
// Self-checking bench: burst memory responder, line-residency reference model,
// directed scenarios, randomized fetch stream, and a narrow miss-counter instance.
module tb_icache_refill_responder;

  localparam int LW = 4;
  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] data;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [15:0] miss_count;

  logic        rst2 = 1'b1;
  logic [31:0] addr2 = '0;
  logic [31:0] data2;
  logic        hit2;
  logic        mem_req2;
  logic [31:0] mem_addr2;
  logic        mem_rvalid2;
  logic [31:0] mem_rdata2;
  logic [1:0]  miss_count2;

  always #5 clk = ~clk;

  icache_refill_responder #(.LINES(NL), .LINE_WORDS(LW), .MISS_W(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .hit(hit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .miss_count(miss_count)
  );

  // Narrow counter instance; its memory answers every cycle a request is up.
  assign mem_rvalid2 = mem_req2;
  assign mem_rdata2  = 32'hC0DE_0000 | mem_addr2;

  icache_refill_responder #(.LINES(NL), .LINE_WORDS(LW), .MISS_W(2)) dut_sat (
    .clk(clk), .rst(rst2), .addr(addr2), .data(data2), .hit(hit2),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_rvalid(mem_rvalid2),
    .mem_rdata(mem_rdata2), .miss_count(miss_count2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / LW) % NL);
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] a);
    return a / (LW * NL);
  endfunction

  // Memory responder: one beat per free cycle, gap_mode idle cycles between beats (-1 = random).
  int gap_mode  = 0;
  int resp_beat = 0;
  int idle_left = 0;

  always @(posedge clk) begin
    logic rst_edge;
    rst_edge = rst;
    #1;
    if (mem_rvalid) begin
      resp_beat++;
      idle_left = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
    end
    mem_rvalid = 1'b0;
    if (rst_edge || !mem_req) begin
      resp_beat = 0;
      idle_left = 0;
    end else if (resp_beat < LW) begin
      if (idle_left > 0) idle_left--;
      else begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(mem_addr + 32'(resp_beat));
      end
    end
  end

  // Reference model: which line is resident, whether a refill is outstanding, and how many started.
  logic        m_busy   = 1'b0;
  int          m_beats  = 0;
  logic [31:0] m_base   = '0;
  logic        m_valid[NL] = '{default: 1'b0};
  logic [31:0] m_tagv[NL]  = '{default: 32'h0};
  int          m_misses = 0;

  always @(negedge clk) begin
    logic exp_hit;
    exp_hit = !m_busy && m_valid[m_idx(addr)] && (m_tagv[m_idx(addr)] == m_tag(addr));
    check("hit", 32'(hit), 32'(exp_hit));
    check("data", data, exp_hit ? mem_word(addr) : 32'h0);
    check("mem_req", 32'(mem_req), 32'(m_busy));
    check("mem_addr", mem_addr, m_base);
    check("miss_count", 32'(miss_count), 32'(m_misses));
    if (rst) begin
      m_busy   = 1'b0;
      m_beats  = 0;
      m_base   = '0;
      m_misses = 0;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else if (!m_busy) begin
      if (!exp_hit) begin
        m_busy  = 1'b1;
        m_beats = 0;
        m_base  = addr & ~32'(LW - 1);
        m_valid[m_idx(addr)] = 1'b0;
        if (m_misses < 65535) m_misses++;
      end
    end else if (mem_rvalid) begin
      m_beats++;
      if (m_beats == LW) begin
        m_busy = 1'b0;
        m_valid[m_idx(m_base)] = 1'b1;
        m_tagv[m_idx(m_base)]  = m_tag(m_base);
      end
    end
  end

  task automatic go(input logic [31:0] a);
    @(posedge clk);
    #1;
    addr = a;
  endtask

  // Called at a negedge; counts further cycles until hit is seen (bounded).
  task automatic wait_hit(input int start, output int lat);
    lat = start;
    while (!hit && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int t;
    int r;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hit", 32'(hit), 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_miss", 32'(miss_count), 32'h0);

    // Cold miss with back-to-back beats
    gap_mode = 0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    addr = 32'h10;
    @(negedge clk);
    check("cold_miss_hit", 32'(hit), 32'h0);
    @(negedge clk);
    check("cold_req", 32'(mem_req), 32'h1);
    check("cold_mem_addr", mem_addr, 32'h10);
    wait_hit(1, lat);
    check("cold_latency", 32'(lat), 32'd5);
    check("cold_data", data, 32'hA000_0010);
    check("cold_miss_count", 32'(miss_count), 32'd1);

    // Sequential hits within the line
    for (int i = 1; i < 4; i++) begin
      go(32'h10 + 32'(i));
      @(negedge clk);
      check("seq_hit", 32'(hit), 32'h1);
      check("seq_data", data, 32'hA000_0010 + 32'(i));
      check("seq_req", 32'(mem_req), 32'h0);
    end

    // Conflict eviction on index 4
    go(32'h30);
    @(negedge clk);
    check("conf_miss", 32'(hit), 32'h0);
    wait_hit(0, lat);
    check("conf_mem_addr", mem_addr, 32'h30);
    check("conf_data", data, 32'hA000_0030);
    go(32'h10);
    @(negedge clk);
    check("evicted_miss", 32'(hit), 32'h0);
    wait_hit(0, lat);
    check("evict_miss_count", 32'(miss_count), 32'd3);
    check("refetch_data", data, 32'hA000_0010);

    // Gapped beats with the fetch address moving mid-fill
    gap_mode = 2;
    go(32'h08);
    @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    addr = 32'h20;
    @(negedge clk);
    t = 0;
    while (mem_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("gap_fill_done", 32'(mem_req), 32'h0);
    t = 0;
    while (!mem_req && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("gap_new_req", 32'(mem_req), 32'h1);
    check("gap_new_mem_addr", mem_addr, 32'h20);
    wait_hit(0, lat);
    check("gap_new_data", data, 32'hA000_0020);
    go(32'h08);
    @(negedge clk);
    check("gap_line_kept", 32'(hit), 32'h1);
    check("gap_line_data", data, 32'hA000_0008);
    check("gap_miss_count", 32'(miss_count), 32'd5);

    // Reset after two of four beats
    gap_mode = 0;
    go(32'h44);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_req", 32'(mem_req), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req", 32'(mem_req), 32'h0);
    check("post_rst_hit", 32'(hit), 32'h0);
    wait_hit(0, lat);
    check("refill_latency", 32'(lat), 32'd5);
    check("refill_data", data, 32'hA000_0044);
    check("refill_miss_count", 32'(miss_count), 32'd1);

    // Randomized fetch stream with random beat gaps and occasional reset
    gap_mode = -1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      r   = int'($urandom_range(0, 99));
      rst = (r < 2);
      if (r < 30)      addr = 32'($urandom_range(0, 127));
      else if (r < 90) addr = (addr + 32'd1) & 32'h7F;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);

    // Miss counter saturation on the 2-bit instance
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr2 = 32'(i * 4);
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("sat_count", 32'(miss_count2), (i + 1 < 3) ? 32'(i + 1) : 32'd3);
      check("sat_hit", 32'(hit2), 32'h1);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/icache_refill_responder.md
# icache_refill_responder

Responder side of the fetch-to-instruction-cache interface: a direct-mapped, word-addressed instruction cache that answers the fetch stage's `addr` with `data` and `hit`. On a miss it runs a line-refill state machine against a backing instruction memory. It sits between the fetch stage's PC register and the instruction memory. It is the block the fetch stage waits on, through `hit`, before advancing the PC.

## Interface
- `LINES`, 8 — number of cache lines (power of two, ≥2)
- `LINE_WORDS`, 4 — 32-bit words per line (power of two, ≥2)
- `MISS_W`, 16 — width of the miss counter
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `addr`  in  32  fetch word address (PC increments by 1 per instruction)
- `data`  out  32  instruction word; 32'h0 whenever `hit`=0
- `hit`  out  1  addressed word is valid in the cache this cycle
- `mem_req`  out  1  refill request, held high for the whole burst
- `mem_addr`  out  32  line base address (offset bits zero), stable while `mem_req`=1
- `mem_rvalid`  in  1  one data beat valid this cycle
- `mem_rdata`  in  32  beat data; beats arrive in ascending word order
- `miss_count`  out  MISS_W  saturating count of refills started

## Operation
- Address split:
  - `OFF_W` = log2(`LINE_WORDS`), `IDX_W` = log2(`LINES`).
  - Offset = `addr[OFF_W-1:0]`; index = `addr[OFF_W+IDX_W-1:OFF_W]`; tag = remaining upper bits.
  - With default parameters: 2 offset bits, 3 index bits, 27 tag bits.
- Storage: per-line valid bit, tag register, and `LINE_WORDS`×32 data array. Reads are asynchronous.
- `hit` = (state==IDLE) && valid[index] && tag match. `data` is the selected word when `hit`=1, else 0.
- FSM states: IDLE, FILL.
  - IDLE → FILL when `hit`=0:
    - latch `mem_addr` = addr with offset bits cleared
    - clear the beat counter
    - clear valid[index] of the latched line
    - assert `mem_req`
    - increment `miss_count`, saturating at all-ones
  - FILL, on each `mem_rvalid`:
    - write `mem_rdata` to word [beat counter] of the latched index
    - increment the beat counter
  - FILL → IDLE on the beat where counter==`LINE_WORDS`-1:
    - set valid and tag of the latched line
    - drop `mem_req` at the same edge
- Fill is never aborted by `addr` changes. The line latched at miss time always completes. If the new `addr` misses after return to IDLE, a new fill starts immediately.
- `hit` is forced 0 throughout FILL, even for addresses in other valid lines.
- `mem_rvalid` in IDLE is ignored.
- Beat counter width is `OFF_W` and wraps to 0 after the last beat.

## Timing
- Hit path is combinational: `addr` change → `hit`/`data` in the same cycle, with zero-cycle latency.
- Miss:
  - `mem_req` rises at the first edge after `hit`=0 is seen in IDLE.
  - `hit`=1 is first possible on the cycle after the edge that captured the last beat.
  - Miss penalty = 1 + (cycles until `LINE_WORDS` beats) + 0. With back-to-back beats and default parameters, `hit` returns 5 cycles after the miss cycle.
- `mem_rvalid` may arrive with any number of idle cycles between beats, including in the same cycle `mem_req` first rises. No beat is taken before `mem_req`=1.
- Reset values (synchronous `rst`):
  - all valid bits 0, state IDLE
  - `mem_req` 0, `mem_addr` 0
  - `miss_count` 0, beat counter 0
  - consequently `hit` 0 and `data` 0
- Tag/data arrays are not reset.
- `rst` mid-fill: the fill is abandoned, no line becomes valid, and `mem_req` drops at that edge. Late beats after reset are ignored in IDLE, or, if a new fill has started, they are taken as its beats. The memory model is therefore required to discard outstanding beats on `rst`.

## Structure
- Shared package `icache_pkg`:
  - FSM state enum (IDLE, FILL)
  - `NOP_INSTR` = 32'h0, used for the miss output value
  - helper functions for offset/index/tag extraction from `LINES`/`LINE_WORDS`
- Natural sub-module: `icache_line_store` — valid/tag/data arrays with asynchronous read port and one synchronous write port (word write + line-valid set/clear).
- FSM, beat counter, and miss counter live in the top.

## Test plan
- Cold miss: after reset, `addr`=0x10.
  - `mem_req`=1, `mem_addr`=0x10.
  - Four back-to-back beats 0xA0000010..0xA0000013.
  - `hit`=1 and `data`=0xA0000010 five cycles after the miss; `miss_count`=1.
- Sequential hits: `addr` 0x11, 0x12, 0x13 on consecutive cycles after the fill → `hit`=1 each cycle, `data`=0xA0000011..13, no `mem_req`.
- Conflict eviction: fill 0x10, then `addr`=0x30 (same index 4, different tag) → refill with `mem_addr`=0x30. Returning to 0x10 misses again; `miss_count`=3.
- Gapped beats plus address change: miss on 0x08. Beats come with 2 idle cycles between them. `addr` is moved to 0x20 during FILL → `hit`=0 throughout, and the 0x08 line completes. Then a new fill starts with `mem_addr`=0x20.
- Reset mid-fill: `rst` after 2 of 4 beats → `mem_req`=0 next cycle. Re-presenting the same address misses and refetches all 4 beats.
- Saturation: with `MISS_W`=2, force 5 misses → `miss_count` holds 3.
